// File: rtl/regfile_wb_queue.sv
// Write-back queue for the register file write port: two producers in, one
// write per cycle out, with two bypass lookups over the queued results.
module regfile_wb_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] lk_reg1,
  output logic              lk_hit1,
  output logic [DATA_W-1:0] lk_data1,
  input  logic [ADDR_W-1:0] lk_reg2,
  output logic              lk_hit2,
  output logic [DATA_W-1:0] lk_data2,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ADDR_W + 1;

  logic [ADDR_W-1:0] q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     free;
  logic              pop;
  logic              mem_take;
  logic              alu_take;
  logic [PW-1:0]     alu_slot;
  logic [PW-1:0]     idx;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = !empty;

  assign wb_en   = pop;
  assign wb_reg  = empty ? '0 : q_reg[rd_ptr];
  assign wb_data = empty ? '0 : q_data[rd_ptr];

  // The head pop at this edge frees a slot, so a full queue still takes one result.
  always_comb begin
    free      = CW'(DEPTH) - cnt + CW'(pop);
    mem_ready = (free >= CW'(1));
    mem_take  = mem_valid & mem_ready & (mem_reg != '0);
    alu_ready = (free >= (CW'(1) + CW'(mem_take)));
    alu_take  = alu_valid & alu_ready & (alu_reg != '0);
    alu_slot  = wr_ptr + PW'(mem_take);
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lk_hit1  = 1'b0;
    lk_data1 = '0;
    lk_hit2  = 1'b0;
    lk_data2 = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < cnt) begin
        if (lk_reg1 != '0 && q_reg[idx] == lk_reg1) begin
          lk_hit1  = 1'b1;
          lk_data1 = q_data[idx];
        end
        if (lk_reg2 != '0 && q_reg[idx] == lk_reg2) begin
          lk_hit2  = 1'b1;
          lk_data2 = q_data[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_reg[PW'(i)]  <= '0;
        q_data[PW'(i)] <= '0;
      end
    end else begin
      if (mem_take) begin
        q_reg[wr_ptr]  <= mem_reg;
        q_data[wr_ptr] <= mem_data;
      end
      if (alu_take) begin
        q_reg[alu_slot]  <= alu_reg;
        q_data[alu_slot] <= alu_data;
      end
      wr_ptr <= wr_ptr + PW'(mem_take) + PW'(alu_take);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt    <= cnt + CW'(mem_take) + CW'(alu_take) - CW'(pop);
    end
  end

endmodule
